// File: rtl/mcast_expander_if.sv
// Handshake bundle for the multicast expander: two-phase input channel
// (req_in/data_in/ack_in) and two-phase unicast output channel (req_out/data_out/ack_out).
interface mcast_expander_if #(
   parameter int MSG_W  = 10,
   parameter int ADDR_W = 5
);
   logic                      req_in;
   logic [MSG_W+ADDR_W-1:0]   data_in;
   logic                      ack_in;
   logic                      req_out;
   logic [MSG_W+ADDR_W-1:0]   data_out;
   logic                      ack_out;

   modport slave (
      input  req_in, data_in, ack_out,
      output ack_in, req_out, data_out
   );

   modport master (
      output req_in, data_in, ack_out,
      input  ack_in, req_out, data_out
   );
endinterface

// File: rtl/mcast_expander.sv
// Multicast-to-unicast expander: buffers {msg, mask} packets and re-emits one
// {msg, one-hot} packet per set mask bit, lowest bit first, with sent/drop counters.
//
// state    | meaning
// IDLE     | no packet in work registers, waiting for FIFO data
// SEND     | emit lowest remaining mask bit, toggle req_out
// WAIT_ACK | wait for synchronised ack_out to match req_out
module mcast_expander #(
   parameter int MSG_W       = 10,
   parameter int ADDR_W      = 5,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   mcast_expander_if.slave      bus,
   input  logic                 clear_cnt,
   output logic [CNT_W-1:0]     sent_cnt,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic                 busy
);
   localparam int DW = MSG_W + ADDR_W;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

   state_t              r_state;
   logic [MSG_W-1:0]    r_msg;
   logic [ADDR_W-1:0]   r_rem;
   logic                r_req_out;
   logic [DW-1:0]       r_data_out;
   logic                r_ack_in;
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [DW-1:0]       r_mem [FIFO_DEPTH];

   logic                w_req_in_s;
   logic                w_ack_out_s;
   logic                w_empty;
   logic                w_full;
   logic                w_accept;
   logic                w_mask_zero;
   logic                w_push;
   logic                w_drop;
   logic                w_acked;
   logic                w_pop;
   logic [DW-1:0]       w_head;
   logic [ADDR_W-1:0]   w_low;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_req_in_s  = bus.req_in;
         assign w_ack_out_s = bus.ack_out;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_req_sync;
         logic [SYNC_STAGES-1:0] r_ack_sync;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_req_sync <= '0;
               r_ack_sync <= '0;
            end else begin
               r_req_sync[0] <= bus.req_in;
               r_ack_sync[0] <= bus.ack_out;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_req_sync[i] <= r_req_sync[i-1];
                  r_ack_sync[i] <= r_ack_sync[i-1];
               end
            end
         end
         assign w_req_in_s  = r_req_sync[SYNC_STAGES-1];
         assign w_ack_out_s = r_ack_sync[SYNC_STAGES-1];
      end
   endgenerate

   // Full is judged on start-of-cycle occupancy, so a same-cycle pop never admits a push.
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_accept    = (w_req_in_s != r_ack_in) && !w_full;
   assign w_mask_zero = (bus.data_in[ADDR_W-1:0] == '0);
   assign w_push      = w_accept && !w_mask_zero;
   assign w_drop      = w_accept && w_mask_zero;
   assign w_acked     = (w_ack_out_s == r_req_out);
   assign w_pop       = !w_empty && ((r_state == IDLE) ||
                        (r_state == WAIT_ACK && w_acked && r_rem == '0));
   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign w_low       = r_rem & (~r_rem + 1'b1);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ack_in <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_accept) r_ack_in <= ~r_ack_in;
         if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_msg      <= '0;
         r_rem      <= '0;
         r_req_out  <= 1'b0;
         r_data_out <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_msg   <= w_head[DW-1:ADDR_W];
                  r_rem   <= w_head[ADDR_W-1:0];
                  r_state <= SEND;
               end
            end
            SEND: begin
               r_data_out <= {r_msg, w_low};
               r_req_out  <= ~r_req_out;
               r_rem      <= r_rem & ~w_low;
               r_state    <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (w_acked) begin
                  if (r_rem != '0) begin
                     r_state <= SEND;
                  end else if (w_pop) begin
                     r_msg   <= w_head[DW-1:ADDR_W];
                     r_rem   <= w_head[ADDR_W-1:0];
                     r_state <= SEND;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Saturating counters; a clear wins over a coincident increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sent_cnt <= '0;
         drop_cnt <= '0;
      end else if (clear_cnt) begin
         sent_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (r_state == SEND && sent_cnt != '1) sent_cnt <= sent_cnt + 1'b1;
         if (w_drop && drop_cnt != '1)          drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign bus.ack_in   = r_ack_in;
   assign bus.req_out  = r_req_out;
   assign bus.data_out = r_data_out;
   assign busy         = !w_empty || (r_state != IDLE);
endmodule

// File: tb/tb_mcast_expander.sv
// Randomised and directed bench for mcast_expander with a queue-based expansion
// model checked every cycle, plus literal expectations for the key scenarios.
module tb_mcast_expander;
   localparam int MSG_W  = 10;
   localparam int ADDR_W = 5;
   localparam int DW     = MSG_W + ADDR_W;
   localparam int DEPTH  = 4;
   localparam int SYNC   = 2;
   localparam int CNT_W  = 4;
   localparam int SAT    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             clear_cnt = 1'b0;
   logic [CNT_W-1:0] sent_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic             busy;

   mcast_expander_if #(.MSG_W(MSG_W), .ADDR_W(ADDR_W)) bus ();

   mcast_expander #(
      .MSG_W(MSG_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH),
      .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .clear_cnt(clear_cnt),
      .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: accepted packets expanded into the unicast stream they must produce.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] obs_q[$];
   int            sent_m = 0;
   int            drop_m = 0;
   logic          p_req = 1'b0, p_ack = 1'b0, p_clr = 1'b0;
   logic [DW-1:0] p_dout = '0, p_din = '0;

   always @(negedge clk) begin
      if (!rst) begin
         check("rst_ack_in", bus.ack_in, 0);
         check("rst_req_out", bus.req_out, 0);
         check("rst_data_out", bus.data_out, 0);
         check("rst_sent_cnt", sent_cnt, 0);
         check("rst_drop_cnt", drop_cnt, 0);
         check("rst_busy", busy, 0);
         exp_q.delete();
         sent_m = 0;
         drop_m = 0;
         p_req  = 1'b0;
         p_ack  = 1'b0;
         p_dout = '0;
      end else begin
         if (bus.req_out !== p_req) begin
            obs_q.push_back(bus.data_out);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_req_out: got data %0h expected no toggle at %0t",
                        bus.data_out, $time);
            end else begin
               check("data_out_order", bus.data_out, exp_q.pop_front());
            end
            if (sent_m < SAT) sent_m++;
         end else begin
            check("data_out_stable", bus.data_out, p_dout);
         end
         if (bus.ack_in !== p_ack) begin
            if (p_din[ADDR_W-1:0] == '0) begin
               if (drop_m < SAT) drop_m++;
            end else begin
               for (int j = 0; j < ADDR_W; j++)
                  if (p_din[j]) exp_q.push_back({p_din[DW-1:ADDR_W], ADDR_W'(1 << j)});
            end
         end
         if (p_clr) begin
            sent_m = 0;
            drop_m = 0;
         end
         check("sent_cnt", sent_cnt, sent_m);
         check("drop_cnt", drop_cnt, drop_m);
         if (exp_q.size() > 0) check("busy_when_pending", busy, 1);
         p_req  = bus.req_out;
         p_ack  = bus.ack_in;
         p_dout = bus.data_out;
      end
      p_clr = clear_cnt;
      p_din = bus.data_in;
   end

   // Downstream responder: acks each req_out toggle after ack_delay cycles unless held.
   logic hold = 1'b0;
   int   ack_delay = 0;
   int   rcnt = 0;
   initial begin
      bus.ack_out = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            bus.ack_out = 1'b0;
            rcnt = 0;
         end else if (!hold && bus.req_out != bus.ack_out) begin
            if (rcnt >= ack_delay) begin
               bus.ack_out = bus.req_out;
               rcnt = 0;
            end else begin
               rcnt++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_req(input logic [MSG_W-1:0] msg, input logic [ADDR_W-1:0] mask);
      bus.data_in = {msg, mask};
      bus.req_in  = ~bus.req_in;
   endtask

   task automatic wait_ack(input int limit, output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < limit && !ok) begin
         tick(1);
         cyc++;
         if (bus.ack_in == bus.req_in) ok = 1'b1;
      end
   endtask

   task automatic send(input logic [MSG_W-1:0] msg, input logic [ADDR_W-1:0] mask);
      int c;
      bit ok;
      start_req(msg, mask);
      wait_ack(1000, c, ok);
      check("ack_in_timeout", ok, 1);
   endtask

   task automatic wait_idle(input int limit);
      int c = 0;
      while (c < limit && !(exp_q.size() == 0 && busy == 1'b0)) begin
         tick(1);
         c++;
      end
      check("drain_timeout", c < limit, 1);
      tick(1);
   endtask

   function automatic logic [DW-1:0] obs_at(input int i);
      logic [DW-1:0] v;
      v = 'x;
      if (i < obs_q.size()) v = obs_q[i];
      return v;
   endfunction

   initial begin
      int c;
      bit ok;
      logic [MSG_W-1:0]  msg;
      logic [ADDR_W-1:0] mask;

      bus.req_in  = 1'b0;
      bus.data_in = '0;
      tick(3);
      rst = 1'b1;
      tick(2);

      // Basic three-bit expansion
      obs_q.delete();
      send(10'h2A5, 5'b10110);
      wait_idle(300);
      check("t1_count", obs_q.size(), 3);
      check("t1_out0", obs_at(0), {10'h2A5, 5'b00010});
      check("t1_out1", obs_at(1), {10'h2A5, 5'b00100});
      check("t1_out2", obs_at(2), {10'h2A5, 5'b10000});
      check("t1_sent_cnt", sent_cnt, 3);
      check("t1_busy", busy, 0);

      // Zero mask is acked and dropped
      obs_q.delete();
      start_req(10'h001, 5'b00000);
      wait_ack(50, c, ok);
      check("t2_ack_latency", c, SYNC + 1);
      tick(10);
      check("t2_no_output", obs_q.size(), 0);
      check("t2_drop_cnt", drop_cnt, 1);

      // Full FIFO back-pressure
      hold = 1'b1;
      obs_q.delete();
      for (int i = 0; i <= DEPTH; i++) send(MSG_W'(10'h100 + i), ADDR_W'(1 << (i % ADDR_W)));
      start_req(10'h1FF, 5'b01000);
      wait_ack(40, c, ok);
      check("t3_full_no_ack", ok, 0);
      hold = 1'b0;
      wait_ack(1000, c, ok);
      check("t3_ack_resumes", ok, 1);
      wait_idle(1000);
      check("t3_count", obs_q.size(), DEPTH + 2);
      check("t3_first", obs_at(0), {10'h100, 5'b00001});
      check("t3_last", obs_at(DEPTH + 1), {10'h1FF, 5'b01000});

      // All-ones mask with slow downstream ack
      clear_cnt = 1'b1;
      tick(1);
      clear_cnt = 1'b0;
      ack_delay = 10;
      obs_q.delete();
      send(10'h155, 5'b11111);
      wait_idle(1000);
      check("t4_count", obs_q.size(), ADDR_W);
      for (int i = 0; i < ADDR_W; i++)
         check("t4_onehot", obs_at(i), {10'h155, ADDR_W'(1 << i)});
      check("t4_sent_cnt", sent_cnt, 5);
      ack_delay = 0;

      // Reset while waiting for an ack with two packets buffered
      hold = 1'b1;
      send(10'h0AA, 5'b00011);
      send(10'h0BB, 5'b00100);
      send(10'h0CC, 5'b11000);
      tick(5);
      check("t5_busy_before", busy, 1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("t5_async_req_out", bus.req_out, 0);
      check("t5_async_data_out", bus.data_out, 0);
      check("t5_async_ack_in", bus.ack_in, 0);
      check("t5_async_busy", busy, 0);
      bus.req_in  = 1'b0;
      bus.data_in = '0;
      hold = 1'b0;
      tick(3);
      rst = 1'b1;
      obs_q.delete();
      tick(20);
      check("t5_no_stale", obs_q.size(), 0);
      send(10'h3C3, 5'b00101);
      wait_idle(300);
      check("t5_count", obs_q.size(), 2);
      check("t5_out0", obs_at(0), {10'h3C3, 5'b00001});
      check("t5_out1", obs_at(1), {10'h3C3, 5'b00100});
      check("t5_sent_cnt", sent_cnt, 2);

      // Saturation and clear priority
      for (int i = 0; i < 4; i++) send(MSG_W'(10'h200 + i), 5'b11111);
      wait_idle(1000);
      check("t6_saturated", sent_cnt, SAT);
      send(10'h211, 5'b00001);
      wait_idle(300);
      check("t6_holds", sent_cnt, SAT);
      clear_cnt = 1'b1;
      send(10'h077, 5'b10101);
      wait_idle(300);
      clear_cnt = 1'b0;
      tick(1);
      check("t6_clear_wins", sent_cnt, 0);

      // Randomised traffic against the model
      for (int n = 0; n < 60; n++) begin
         msg       = MSG_W'($urandom_range(0, 1023));
         mask      = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
         ack_delay = $urandom_range(0, 4);
         clear_cnt = ($urandom_range(0, 9) == 0);
         send(msg, mask);
      end
      clear_cnt = 1'b0;
      wait_idle(3000);
      check("rand_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mcast_expander.md
Name: mcast_expander

Overview:
Synchronous multicast-to-unicast expander for the switch local (L1) injection path. It accepts packets of {message, destination bitmask} on a two-phase req/ack channel and buffers them in a FIFO. Each packet is re-emitted as one unicast packet per set mask bit, lowest bit first, on a two-phase output channel. Per-block counters track unicast packets sent and zero-mask packets dropped.

Parameters:
MSG_W, 10, message field width (upper bits of packet)
ADDR_W, 5, destination bitmask width (lower bits of packet); bit j = destination j
FIFO_DEPTH, 4, input packet buffer entries; power of 2, >=2
SYNC_STAGES, 2, flop stages on req_in and ack_out; 0 = direct sampling
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_in  in  1  two-phase request; a toggle means data_in is valid and stable
data_in  in  MSG_W+ADDR_W  {msg, mask}; held stable until ack_in toggles
ack_in  out  1  two-phase acknowledge for the input channel
req_out  out  1  two-phase request for the output channel
data_out  out  MSG_W+ADDR_W  {msg, one-hot address}
ack_out  in  1  two-phase acknowledge from the downstream stage
clear_cnt  in  1  synchronous clear of both counters
sent_cnt  out  CNT_W  unicast packets emitted
drop_cnt  out  CNT_W  zero-mask packets accepted and discarded
busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (rst=0, async): ack_in=0, req_out=0, data_out=0, counters=0, busy=0, FIFO empty, FSM=IDLE, synchroniser flops=0.
- Reset mid-operation discards all buffered and in-flight packets. The environment must reset its req/ack phase together with the block.
- Input capture: when req_in_s != ack_in (req_in_s = synchronised req_in):
  - If FIFO not full: at the next edge, write data_in (mask != 0) or increment drop_cnt (mask == 0), and toggle ack_in.
  - If FIFO full: no ack and no write. The request stays pending until a pop frees an entry. Push is evaluated against occupancy at the start of the cycle, so a same-cycle pop does not admit a push when full.
- FSM states IDLE, SEND, WAIT_ACK. Work registers: msg_r, rem_r (remaining mask).
  - IDLE: if FIFO non-empty, pop into msg_r/rem_r and go to SEND.
  - SEND: let k = lowest set bit of rem_r. Drive data_out={msg_r, 1<<k}, toggle req_out, clear rem_r[k], increment sent_cnt, go to WAIT_ACK.
  - WAIT_ACK: wait for ack_out_s == req_out. Then:
    - rem_r != 0: go to SEND.
    - Else if FIFO non-empty: pop and go to SEND.
    - Else: go to IDLE.
- data_out is stable from its req_out toggle until the matching ack. It keeps its last value while idle.
- Latency with an empty FIFO and idle FSM: ack_in toggles SYNC_STAGES+1 edges after the req_in toggle. The first req_out toggle follows SYNC_STAGES+3 edges after the req_in toggle.
- Per-bit throughput: 1 SEND cycle + ack round trip + SYNC_STAGES.
- Counters saturate at 2^CNT_W-1. clear_cnt takes priority over an increment in the same cycle.
- Ordering: packets leave in FIFO order; within a packet, ascending bit index. The sum over emitted one-hot addresses equals the input mask.
- All-ones mask emits exactly ADDR_W packets.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra occupancy bit.

Test Plan:
- Reset, then mask=5'b10110, msg=10'h2A5 -> three outputs {2A5,00010},{2A5,00100},{2A5,10000} in that order; sent_cnt=3; busy=0 after last ack.
- Mask=0, msg=10'h001 -> ack_in toggles within SYNC_STAGES+1 cycles; no req_out toggle; drop_cnt=1.
- Hold ack_out constant, send FIFO_DEPTH+1 single-bit packets -> the first is popped and later FIFO_DEPTH are buffered. The (FIFO_DEPTH+2)th req gets no ack until ack_out resumes; then all are delivered in order, none lost.
- Mask=5'b11111 with back_ack-style 10-cycle ack delay -> 5 outputs with addresses 00001..10000; sent_cnt=5.
- Assert rst mid-WAIT_ACK with 2 packets buffered -> all outputs 0 immediately; after release no stale req_out toggle; a new packet is processed normally.
- Drive sent_cnt to 2^CNT_W-1 (CNT_W=4 build), then send one more packet -> counter holds at 15. clear_cnt asserted in the same cycle as an increment -> 0.
